// File: rtl/usr_pkg.sv
// Shared types for the universal shift register: shift op codes and
// burst engine states.
package usr_pkg;

  typedef enum logic [2:0] {
    OP_HOLD = 3'd0,
    OP_SHL  = 3'd1,
    OP_SHR  = 3'd2,
    OP_ROL  = 3'd3,
    OP_ROR  = 3'd4,
    OP_ASR  = 3'd5
  } shift_op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BURST = 2'd1,
    S_DONE  = 2'd2
  } usr_state_e;

endpackage

// File: rtl/usr_shift_unit.sv
// Combinational shift/rotate unit shared by the single-step and burst paths.
// o_shifted flags that a real shift/rotate happened so the caller knows
// whether to capture o_out; HOLD and reserved codes leave q untouched.
module usr_shift_unit
  import usr_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] i_q,
  input  shift_op_e    i_op,
  input  logic         i_sh_in,
  output logic [W-1:0] o_q,
  output logic         o_out,
  output logic         o_shifted
);

  // Select the next register value and the bit that falls out.
  always_comb begin
    o_q       = i_q;
    o_out     = 1'b0;
    o_shifted = 1'b0;
    case (i_op)
      OP_SHL: begin
        o_q       = {i_q[W-2:0], i_sh_in};
        o_out     = i_q[W-1];
        o_shifted = 1'b1;
      end
      OP_SHR: begin
        o_q       = {i_sh_in, i_q[W-1:1]};
        o_out     = i_q[0];
        o_shifted = 1'b1;
      end
      OP_ROL: begin
        o_q       = {i_q[W-2:0], i_q[W-1]};
        o_out     = i_q[W-1];
        o_shifted = 1'b1;
      end
      OP_ROR: begin
        o_q       = {i_q[0], i_q[W-1:1]};
        o_out     = i_q[0];
        o_shifted = 1'b1;
      end
      OP_ASR: begin
        o_q       = {i_q[W-1], i_q[W-1:1]};
        o_out     = i_q[0];
        o_shifted = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register with single-step ops and a counted burst engine.
// Optional even-parity output qPar is built when USR_PARITY_EN is defined.
//
// state   | meaning
// S_IDLE  | single-step mode, op applied every cycle, start may be accepted
// S_BURST | latched op applied each cycle until the counter expires (busy)
// S_DONE  | one-cycle done pulse; behaves like S_IDLE for new commands
module univ_shift_reg
  import usr_pkg::*;
#(
  parameter int W    = 8,
  parameter int CNTW = $clog2(W + 1)
) (
  input  logic            ck,
  input  logic            rst,
  input  logic            clr,
  input  logic            ld,
  input  logic [W-1:0]    d,
  input  logic [2:0]      op,
  input  logic            shIn,
  input  logic            start,
  input  logic [CNTW-1:0] nShift,
  output logic [W-1:0]    q,
  output logic            shOut,
  output logic            busy,
  output logic            done
`ifdef USR_PARITY_EN
  ,
  output logic            qPar
`endif
);

  usr_state_e      r_state;
  usr_state_e      w_state_d;
  logic [CNTW-1:0] r_cnt;
  logic [CNTW-1:0] w_cnt_d;
  shift_op_e       r_op;
  shift_op_e       w_op_d;
  logic [W-1:0]    r_q;
  logic [W-1:0]    w_q_d;
  logic            r_sh_out;
  logic            w_sh_out_d;

  shift_op_e       w_unit_op;
  logic [W-1:0]    w_unit_q;
  logic            w_unit_out;
  logic            w_unit_shifted;

  // During a burst the latched op drives the shifter; otherwise the live op.
  assign w_unit_op = (r_state == S_BURST) ? r_op : shift_op_e'(op);

  usr_shift_unit #(.W(W)) u_shift (
    .i_q       (r_q),
    .i_op      (w_unit_op),
    .i_sh_in   (shIn),
    .o_q       (w_unit_q),
    .o_out     (w_unit_out),
    .o_shifted (w_unit_shifted)
  );

  // Next-state and datapath decode: clr > ld > burst step > start > single step.
  always_comb begin
    w_state_d  = r_state;
    w_cnt_d    = r_cnt;
    w_op_d     = r_op;
    w_q_d      = r_q;
    w_sh_out_d = r_sh_out;
    if (clr) begin
      w_q_d      = '0;
      w_sh_out_d = 1'b0;
      w_cnt_d    = '0;
      w_state_d  = S_IDLE;
    end else if (ld) begin
      w_q_d      = d;
      w_sh_out_d = 1'b0;
      w_cnt_d    = '0;
      w_state_d  = S_IDLE;
    end else if (r_state == S_BURST) begin
      w_q_d   = w_unit_q;
      if (w_unit_shifted) w_sh_out_d = w_unit_out;
      w_cnt_d = r_cnt - CNTW'(1);
      if (r_cnt == CNTW'(1)) w_state_d = S_DONE;
    end else if (start) begin
      w_op_d    = shift_op_e'(op);
      w_cnt_d   = nShift;
      w_state_d = (nShift == '0) ? S_DONE : S_BURST;
    end else begin
      w_q_d     = w_unit_q;
      if (w_unit_shifted) w_sh_out_d = w_unit_out;
      w_state_d = S_IDLE;
    end
  end

  // FSM state register.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_d;
  end

  // Datapath registers: contents, out bit, burst counter and latched op.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      r_q      <= '0;
      r_sh_out <= 1'b0;
      r_cnt    <= '0;
      r_op     <= OP_HOLD;
    end else begin
      r_q      <= w_q_d;
      r_sh_out <= w_sh_out_d;
      r_cnt    <= w_cnt_d;
      r_op     <= w_op_d;
    end
  end

`ifdef USR_PARITY_EN
  logic r_par;

  // Parity is taken from the next value so it stays aligned with q.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) r_par <= 1'b0;
    else     r_par <= ^w_q_d;
  end

  assign qPar = r_par;
`endif

  assign q     = r_q;
  assign shOut = r_sh_out;
  assign busy  = (r_state == S_BURST);
  assign done  = (r_state == S_DONE);

endmodule

// File: tb/tb_univ_shift_reg.sv
// Scoreboard bench for univ_shift_reg: a behavioural model predicts each
// cycle's outputs into a queue; a monitor pops and compares after each edge.
module tb_univ_shift_reg;
  localparam int W    = 8;
  localparam int CNTW = $clog2(W + 1);

  logic            ck = 1'b0;
  logic            rst, clr, ld, shIn, start;
  logic [W-1:0]    d;
  logic [2:0]      op;
  logic [CNTW-1:0] nShift;
  logic [W-1:0]    q;
  logic            shOut, busy, done;
`ifdef USR_PARITY_EN
  logic            qPar;
`endif

  univ_shift_reg #(.W(W), .CNTW(CNTW)) dut (
    .ck(ck), .rst(rst), .clr(clr), .ld(ld), .d(d), .op(op), .shIn(shIn),
    .start(start), .nShift(nShift), .q(q), .shOut(shOut), .busy(busy),
    .done(done)
`ifdef USR_PARITY_EN
    , .qPar(qPar)
`endif
  );

  always #5 ck = ~ck;

  typedef struct packed {
    logic [W-1:0] q;
    logic         so;
    logic         busy;
    logic         done;
    logic         par;
  } exp_t;

  exp_t sb_q[$];
  int vectors = 0;
  int miscompares = 0;

  // Model state: register contents, out bit, remaining burst steps, op.
  int unsigned m_q;
  int unsigned m_so;
  int          m_rem;
  int          m_lop;
  bit          m_done;

  function automatic void chk(string nm, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endfunction

  // Apply one op arithmetically; returns moved=0 for hold/reserved codes.
  function automatic void apply_op(input int o, input int unsigned v, input int unsigned si,
                                   output int unsigned nv, output int unsigned nso,
                                   output bit moved);
    int unsigned mask = (1 << W) - 1;
    int unsigned msb  = v >> (W - 1);
    int unsigned lsb  = v % 2;
    nv = v; nso = 0; moved = 1;
    case (o)
      1: begin nv = (v * 2 + si) & mask;             nso = msb; end
      2: begin nv = (v / 2) + si * (1 << (W - 1));   nso = lsb; end
      3: begin nv = ((v * 2) & mask) + msb;          nso = msb; end
      4: begin nv = (v / 2) + lsb * (1 << (W - 1));  nso = lsb; end
      5: begin nv = (v / 2) + msb * (1 << (W - 1));  nso = lsb; end
      default: moved = 0;
    endcase
  endfunction

  function automatic void model_reset();
    m_q = 0; m_so = 0; m_rem = 0; m_lop = 0; m_done = 0;
  endfunction

  function automatic void model_step(bit c, bit l, int unsigned dd, int o,
                                     int unsigned si, bit st, int n);
    int unsigned nv, nso;
    bit mv;
    m_done = 0;
    if (c) begin
      m_q = 0; m_so = 0; m_rem = 0;
    end else if (l) begin
      m_q = dd; m_so = 0; m_rem = 0;
    end else if (m_rem > 0) begin
      apply_op(m_lop, m_q, si, nv, nso, mv);
      m_q = nv;
      if (mv) m_so = nso;
      m_rem--;
      if (m_rem == 0) m_done = 1;
    end else if (st) begin
      if (n == 0) m_done = 1;
      else begin m_rem = n; m_lop = o; end
    end else begin
      apply_op(o, m_q, si, nv, nso, mv);
      m_q = nv;
      if (mv) m_so = nso;
    end
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    logic [W-1:0] qq;
    qq = W'(m_q);
    e.q    = qq;
    e.so   = m_so[0];
    e.busy = (m_rem > 0);
    e.done = m_done;
    e.par  = ^qq;
    return e;
  endfunction

  // One clock of stimulus: drive at negedge, predict, enqueue expectation.
  task automatic cycle(input bit r, input bit c, input bit l, input logic [W-1:0] dd,
                       input int o, input bit si, input bit st, input int n);
    @(negedge ck);
    rst = r; clr = c; ld = l; d = dd; op = 3'(o); shIn = si; start = st;
    nShift = CNTW'(n);
    if (r) begin
      model_reset();
      #1;
      chk("async_rst_q", int'(q), 0);
      chk("async_rst_busy", int'(busy), 0);
      chk("async_rst_done", int'(done), 0);
      chk("async_rst_shout", int'(shOut), 0);
    end else begin
      model_step(c, l, dd, o, si, st, n);
    end
    sb_q.push_back(model_out());
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cycle(0, 0, 0, '0, 0, 0, 0, 0);
  endtask

  task automatic after_edge();
    @(posedge ck);
    #2;
  endtask

  // Monitor: compare DUT outputs against the oldest expectation every edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge ck);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("q", int'(q), int'(e.q));
        chk("shOut", int'(shOut), int'(e.so));
        chk("busy", int'(busy), int'(e.busy));
        chk("done", int'(done), int'(e.done));
`ifdef USR_PARITY_EN
        chk("qPar", int'(qPar), int'(e.par));
`endif
      end
    end
  end

  initial begin
    rst = 1'b1; clr = 0; ld = 0; d = '0; op = '0; shIn = 0; start = 0; nShift = '0;
    model_reset();
    cycle(1, 0, 0, '0, 0, 0, 0, 0);
    idle(2);

    // Reset in the middle of a ROL burst.
    cycle(0, 0, 1, 8'hA5, 0, 0, 0, 0);
    cycle(0, 0, 0, '0, 3, 0, 1, 5);
    idle(2);
    cycle(1, 0, 0, '0, 0, 0, 0, 0);
    idle(1);

    // Single-step SHL then ASR.
    cycle(0, 0, 1, 8'h81, 0, 0, 0, 0);
    cycle(0, 0, 0, '0, 1, 1, 0, 0);
    after_edge();
    chk("step_shl_q", int'(q), 'h03);
    chk("step_shl_so", int'(shOut), 1);
    cycle(0, 0, 0, '0, 5, 0, 0, 0);
    after_edge();
    chk("step_asr_q", int'(q), 'h01);
    chk("step_asr_so", int'(shOut), 1);

    // ROR burst of 4 with noise on op/shIn.
    cycle(0, 0, 1, 8'hA5, 0, 0, 0, 0);
    cycle(0, 0, 0, '0, 4, 0, 1, 4);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, '0, 1, 1, 0, 0);
    chk("ror4_q_visible", 1, 1);
    after_edge();
    chk("ror4_q", int'(q), 'h5A);
    chk("ror4_done", int'(done), 1);
    idle(2);

    // ROL burst longer than the width wraps around.
    cycle(0, 0, 1, 8'h3C, 0, 0, 0, 0);
    cycle(0, 0, 0, '0, 3, 0, 1, 9);
    idle(9);
    after_edge();
    chk("rol9_q", int'(q), 'h78);
    idle(2);

    // Zero-length burst: done next cycle, q unchanged.
    cycle(0, 0, 0, '0, 1, 1, 1, 0);
    after_edge();
    chk("zero_len_done", int'(done), 1);
    chk("zero_len_q", int'(q), 'h78);

    // clr aborts an SHR burst with no done pulse.
    cycle(0, 0, 1, 8'hF0, 0, 0, 0, 0);
    cycle(0, 0, 0, '0, 2, 0, 1, 6);
    idle(2);
    cycle(0, 1, 0, '0, 0, 0, 0, 0);
    idle(3);

    // start while busy is ignored.
    cycle(0, 0, 1, 8'h5B, 0, 0, 0, 0);
    cycle(0, 0, 0, '0, 1, 0, 1, 3);
    cycle(0, 0, 0, '0, 3, 1, 1, 2);
    idle(5);

    // Randomised traffic.
    for (int i = 0; i < 1500; i++) begin
      cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 49) == 0),
            ($urandom_range(0, 19) == 0), W'($urandom), int'($urandom_range(0, 7)),
            $urandom_range(0, 1) == 1, ($urandom_range(0, 7) == 0),
            int'($urandom_range(0, 12)));
    end
    idle(2);

    repeat (3) @(posedge ck);
    #3;
    chk("scoreboard_drained", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
